// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one outstanding memory request feeding a small {pc, instr} buffer.
// Optional IFETCH_MISALIGN_CHECK_EN turns misaligned PCs into flagged NOP entries without touching memory.
module instruction_fetch #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [XLEN-1:0] pc,
    input  logic            redirect,
    output logic            pc_load,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
`ifdef IFETCH_MISALIGN_CHECK_EN
    output logic [XLEN-1:0] if_pc,
    output logic            if_misaligned
`else
    output logic [XLEN-1:0] if_pc
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t          state;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [XLEN-1:0] tag;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic            has_space;
    logic            misaligned;
    logic            can_issue;
    logic            accept;
    logic            resp_push;
    logic            mis_push;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] push_pc;
    logic [31:0]     push_instr;

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic            mis_mem [DEPTH];
    assign misaligned    = (pc[1:0] != 2'b00);
    assign if_misaligned = mis_mem[rd_ptr];
`else
    assign misaligned    = 1'b0;
`endif

    // Only IDLE may start a fetch, so an empty slot here also covers the response still to come.
    assign has_space  = (count < DEPTH_W);
    assign can_issue  = !RST && (state == IDLE) && has_space && !redirect;
    assign imem_req   = can_issue && !misaligned;
    assign mis_push   = can_issue && misaligned;
    assign accept     = imem_req && imem_gnt;
    assign imem_addr  = pc;
    assign pc_load    = !RST && (accept || redirect || mis_push);

    assign resp_push  = !RST && (state == WAIT) && imem_rvalid && !redirect;
    assign push       = resp_push || mis_push;
    assign pop        = if_valid && if_ready && !redirect;
    assign push_pc    = mis_push ? pc : tag;
    assign push_instr = mis_push ? 32'h0000_0013 : imem_rdata;

    assign if_valid   = (count != '0);
    assign if_instr   = instr_mem[rd_ptr];
    assign if_pc      = pc_mem[rd_ptr];

    // Buffer storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
`ifdef IFETCH_MISALIGN_CHECK_EN
            mis_mem[wr_ptr]   <= mis_push;
`endif
        end
    end

    // Control state. A redirect flushes everything and, if a response is still owed, waits it out in
    // DISCARD; a response arriving in the very cycle of the redirect is already dropped, so return to IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            tag    <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            if ((((state == WAIT) || (state == DISCARD)) && !imem_rvalid) ||
                ((state == IDLE) && imem_gnt))
                state <= DISCARD;
            else
                state <= IDLE;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= WAIT;
                        tag   <= pc;
                    end
                end
                WAIT: begin
                    if (imem_rvalid)
                        state <= IDLE;
                end
                DISCARD: begin
                    if (imem_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch (DEPTH=2, XLEN=64).
// Exercises the IFETCH_MISALIGN_CHECK_EN path when that macro is defined for the build.
module tb_instruction_fetch;

    logic        CLK;
    logic        RST;
    logic [63:0] pc;
    logic        redirect;
    logic        pc_load;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        if_misaligned;
`endif

    logic [63:0] target;
    int          n_checks;
    int          n_fail;

    instruction_fetch #(.DEPTH(2), .XLEN(64)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .pc          (pc),
        .redirect    (redirect),
        .pc_load     (pc_load),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
`ifdef IFETCH_MISALIGN_CHECK_EN
        .if_pc       (if_pc),
        .if_misaligned(if_misaligned)
`else
        .if_pc       (if_pc)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                                 input logic ready, input logic redir);
        imem_gnt    = gnt;
        imem_rvalid = rvalid;
        imem_rdata  = rdata;
        if_ready    = ready;
        redirect    = redir;
        #1;
    endtask

    // Advances one clock and models the external PC register (+4 on load, target on redirect).
    task automatic nextCycle();
        logic ld;
        logic rd;
        ld = pc_load;
        rd = redirect;
        @(posedge CLK);
        #1;
        if (ld)
            pc = rd ? target : pc + 64'd4;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b1;
        pc       = 64'h0;
        target   = 64'h0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("reset_if_valid", {63'd0, if_valid}, 64'd0);
        checkOutput("reset_imem_req", {63'd0, imem_req}, 64'd0);
        checkOutput("reset_pc_load",  {63'd0, pc_load},  64'd0);

`ifdef IFETCH_MISALIGN_CHECK_EN
        RST = 1'b0;
        pc  = 64'h2;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("mis_no_req",  {63'd0, imem_req}, 64'd0);
        checkOutput("mis_pc_load", {63'd0, pc_load},  64'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("mis_valid", {63'd0, if_valid},      64'd1);
        checkOutput("mis_pc",    if_pc,                  64'h2);
        checkOutput("mis_instr", {32'd0, if_instr},      64'h13);
        checkOutput("mis_flag",  {63'd0, if_misaligned}, 64'd1);
        RST = 1'b1;
        nextCycle();
        pc  = 64'h0;
`endif

        // Basic fetch at 0x0
        RST = 1'b0;
        pc  = 64'h0;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("f0_req",     {63'd0, imem_req}, 64'd1);
        checkOutput("f0_addr",    imem_addr,         64'h0);
        checkOutput("f0_pc_load", {63'd0, pc_load},  64'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h0050_0093, 1'b1, 1'b0);
        checkOutput("f0_wait_req",  {63'd0, imem_req}, 64'd0);
        checkOutput("f0_wait_load", {63'd0, pc_load},  64'd0);
        checkOutput("f0_wait_valid",{63'd0, if_valid}, 64'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("f0_valid", {63'd0, if_valid}, 64'd1);
        checkOutput("f0_if_pc", if_pc,             64'h0);
        checkOutput("f0_instr", {32'd0, if_instr}, 64'h0050_0093);
        checkOutput("f1_req",   {63'd0, imem_req}, 64'd1);
        checkOutput("f1_addr",  imem_addr,         64'h4);

        // Fill the buffer with decode stalled
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h00a0_0113, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("full_req",    {63'd0, imem_req}, 64'd0);
        checkOutput("full_load",   {63'd0, pc_load},  64'd0);
        checkOutput("full_head",   if_pc,             64'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("full_req2",   {63'd0, imem_req}, 64'd0);
        checkOutput("full_head2",  if_pc,             64'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("pop_if_pc", if_pc,             64'h4);
        checkOutput("pop_instr", {32'd0, if_instr}, 64'h00a0_0113);
        checkOutput("pop_req",   {63'd0, imem_req}, 64'd1);
        checkOutput("pop_addr",  imem_addr,         64'h8);

        // Redirect while waiting for 0x8
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        target = 64'h100;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("rw_pc_load", {63'd0, pc_load},  64'd1);
        checkOutput("rw_req",     {63'd0, imem_req}, 64'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'hdead_beef, 1'b0, 1'b0);
        checkOutput("rw_empty",   {63'd0, if_valid}, 64'd0);
        checkOutput("rw_disc_req",{63'd0, imem_req}, 64'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("rw_dropped", {63'd0, if_valid}, 64'd0);
        checkOutput("rw_req_new", {63'd0, imem_req}, 64'd1);
        checkOutput("rw_addr",    imem_addr,         64'h100);

        // Redirect coincident with a grant
        target = 64'h200;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("rg_req",     {63'd0, imem_req}, 64'd0);
        checkOutput("rg_pc_load", {63'd0, pc_load},  64'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0);
        checkOutput("rg_disc_req", {63'd0, imem_req}, 64'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("rg_no_push", {63'd0, if_valid}, 64'd0);
        checkOutput("rg_addr",    imem_addr,         64'h200);

        // Simultaneous push and pop across the pointer wrap
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("pp_addr", imem_addr, 64'h204);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h3333_3333, 1'b1, 1'b0);
        checkOutput("pp_head_before", if_pc, 64'h200);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("pp_valid", {63'd0, if_valid}, 64'd1);
        checkOutput("pp_if_pc", if_pc,             64'h204);
        checkOutput("pp_instr", {32'd0, if_instr}, 64'h3333_3333);
        checkOutput("pp_req",   {63'd0, imem_req}, 64'd1);
        checkOutput("pp_addr2", imem_addr,         64'h208);

        // Reset while a fetch is outstanding, then a late response
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        RST = 1'b1;
        #1;
        checkOutput("rst_wait_valid", {63'd0, if_valid}, 64'd0);
        checkOutput("rst_wait_req",   {63'd0, imem_req}, 64'd0);
        checkOutput("rst_wait_load",  {63'd0, pc_load},  64'd0);
        nextCycle();
        RST = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h4444_4444, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("rst_late_rvalid", {63'd0, if_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning fetch-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 64, meaning address/PC width.
REQ-003 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pc  input  XLEN  current PC register value, i.e. the address to fetch.
REQ-006 SHALL have port redirect  input  1  branch/jump taken this cycle; flush all fetched state.
REQ-007 SHALL have port pc_load  output  1  drives the PC register LOAD; PC advances on the next edge.
REQ-008 SHALL have port imem_req  output  1  instruction-memory request valid.
REQ-009 SHALL have port imem_addr  output  XLEN  request address.
REQ-010 SHALL have port imem_gnt  input  1  memory accepts the request this cycle.
REQ-011 SHALL have port imem_rvalid  input  1  response data valid.
REQ-012 SHALL have port imem_rdata  input  32  response instruction word.
REQ-013 SHALL have port if_valid  output  1  decode-side entry valid.
REQ-014 SHALL have port if_ready  input  1  decode consumes the head entry when if_valid && if_ready.
REQ-015 SHALL have port if_instr  output  32  head instruction.
REQ-016 SHALL have port if_pc  output  XLEN  PC of the head instruction.

Function
REQ-017 SHALL implement a FIFO of DEPTH entries {pc, instr}; if_valid = not empty; if_instr/if_pc = head entry, combinational from storage.
REQ-018 SHALL implement an FSM with states IDLE, WAIT, DISCARD; at most one memory request outstanding.
REQ-019 IDLE: SHALL assert imem_req with imem_addr = pc when (occupancy + 0) < DEPTH and redirect = 0; on imem_gnt go to WAIT and latch pc as the tag.
REQ-020 pc_load SHALL equal (imem_req && imem_gnt) || redirect, so PC advances exactly once per accepted fetch and loads the target on redirect.
REQ-021 WAIT: imem_req SHALL be 0; on imem_rvalid push {tag, imem_rdata} and return to IDLE; a new request SHALL NOT be issued in the same cycle (one bubble per fetch).
REQ-022 Space check SHALL reserve a slot for the outstanding fetch; a response is never dropped for lack of space.
REQ-023 A simultaneous push and pop SHALL keep occupancy unchanged; pointers wrap modulo DEPTH.
REQ-024 redirect SHALL empty the FIFO on the next edge and deassert imem_req that cycle; if in WAIT, or if imem_gnt arrives in the same cycle, go to DISCARD.
REQ-025 DISCARD: SHALL drop the response on imem_rvalid without pushing and return to IDLE; a further redirect while in DISCARD stays in DISCARD.
REQ-026 redirect SHALL take priority over push and pop in the same cycle; a pop during redirect has no effect.

Reset
REQ-027 RST high SHALL immediately force state IDLE, FIFO empty, pointers 0, tag 0; if_valid, imem_req, pc_load = 0.
REQ-028 Reset asserted mid-fetch SHALL abandon the outstanding request; a late imem_rvalid with state IDLE SHALL be ignored.

Configuration
REQ-029 With IFETCH_MISALIGN_CHECK_EN defined, SHALL add output if_misaligned (1 bit, per entry): when pc[1:0] != 0 in IDLE, no memory request is issued; an entry {pc, 32'h00000013} with if_misaligned = 1 is pushed directly and pc_load pulses.
REQ-030 Without IFETCH_MISALIGN_CHECK_EN, port if_misaligned SHALL be absent and pc[1:0] is passed to imem_addr unchanged.

Verification
REQ-031 Reset, pc=0x0, gnt=1, rvalid one cycle later with 0x00500093, if_ready=1 -> if_valid with if_pc=0x0, if_instr=0x00500093; next request at 0x4.
REQ-032 if_ready=0, DEPTH=2 -> exactly two entries (0x0, 0x4) buffered, imem_req stays 0 until a pop.
REQ-033 redirect while in WAIT for 0x8 -> FIFO empty, the response for 0x8 is dropped, pc_load=1, next request uses the new pc 0x100.
REQ-034 redirect coincident with imem_gnt -> DISCARD entered; no entry pushed for that address.
REQ-035 RST asserted in WAIT, then rvalid -> nothing pushed, if_valid=0.
REQ-036 With IFETCH_MISALIGN_CHECK_EN, pc=0x2 -> no imem_req; entry if_pc=0x2, if_instr=0x00000013, if_misaligned=1.
